alu_4_bit_sched: RTL and testbench

Round-robin scheduler that shares one `alu_4_bit` instance between `NUM_REQ` requesters. It accepts operations over a valid/ready handshake, drives the ALU operand and mode registers, and waits the ALU's registered latency. It then returns the 8-bit result, tagged with the requester index, on a single response port. It sits between the requester blocks and the `alu_4_bit` datapath, and is the only driver of the ALU inputs.

---
 rtl/alu_sched_pkg.sv | 27 ++
 rtl/rr_arbiter.sv | 38 +++
 rtl/alu_4_bit_sched.sv | 170 +++++++++++++++++
 tb/tb_alu_4_bit_sched.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_sched_pkg.sv
`default_nettype none
// =============================================================================
// Module   : alu_sched_pkg
// Purpose  : Shared ALU mode codes, scheduler state type and error payload.
// Revision : 1.0 - initial release
// =============================================================================
package alu_sched_pkg;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_MUL  = 3'b010;
  localparam logic [2:0] ALU_DIV  = 3'b011;
  localparam logic [2:0] ALU_AND  = 3'b100;
  localparam logic [2:0] ALU_OR   = 3'b101;
  localparam logic [2:0] ALU_MUL2 = 3'b110;
  localparam logic [2:0] ALU_NOT  = 3'b111;

  localparam logic [7:0] ERR_DATA = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin pick: first set request at or after ptr.
// Revision : 1.0 - initial release
// =============================================================================
module rr_arbiter
  import alu_sched_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  int c;

  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    c     = 0;
    for (int k = 0; k < N; k++) begin
      c = int'(ptr_i) + k;
      if (c >= N) c = c - N;
      if (!any_o && req_i[c[IW-1:0]]) begin
        any_o = 1'b1;
        idx_o = c[IW-1:0];
      end
    end
    grant_o = any_o ? (N'(1) << idx_o) : '0;
  end

endmodule
`default_nettype wire

// File: rtl/alu_4_bit_sched.sv
`default_nettype none
// =============================================================================
// Module   : alu_4_bit_sched
// Purpose  : Round-robin scheduler sharing one alu_4_bit between NUM_REQ users.
//            Define ALU_SCHED_DIV0_CHECK_EN to answer divide-by-zero locally.
// Revision : 1.0 - initial release
// =============================================================================
module alu_4_bit_sched
  import alu_sched_pkg::*;
#(
  parameter int  NUM_REQ     = 4,
  parameter int  ALU_LATENCY = 1,
  localparam int IDW         = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [4*NUM_REQ-1:0]   req_a,
  input  logic [4*NUM_REQ-1:0]   req_b,
  input  logic [3*NUM_REQ-1:0]   req_mode,
  output logic [3:0]             alu_a,
  output logic [3:0]             alu_b,
  output logic [2:0]             alu_mode,
  input  logic [7:0]             alu_y,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [7:0]             rsp_data,
  output logic                   rsp_err
);

  localparam int CNT_W = 3;

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [3:0]       alu_a_q, alu_b_q;
  logic [2:0]       alu_mode_q;
  logic [IDW-1:0]   rsp_id_q;
  logic [7:0]       rsp_data_q;

  logic [NUM_REQ-1:0] grant;
  logic [IDW-1:0]     gnt_idx;
  logic               gnt_any;
  logic               accept;
  logic               div0;

  logic [3:0] a_arr    [NUM_REQ];
  logic [3:0] b_arr    [NUM_REQ];
  logic [2:0] mode_arr [NUM_REQ];
  logic [3:0] sel_a, sel_b;
  logic [2:0] sel_mode;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign a_arr[i]    = req_a[4*i +: 4];
    assign b_arr[i]    = req_b[4*i +: 4];
    assign mode_arr[i] = req_mode[3*i +: 3];
  end

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IDW)
  ) u_arb (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .idx_o   (gnt_idx),
    .any_o   (gnt_any)
  );

  assign sel_a    = a_arr[gnt_idx];
  assign sel_b    = b_arr[gnt_idx];
  assign sel_mode = mode_arr[gnt_idx];
  assign accept   = (state_q == IDLE) && gnt_any;

`ifdef ALU_SCHED_DIV0_CHECK_EN
  assign div0 = (sel_mode == ALU_DIV) && (sel_b == 4'd0);
`else
  assign div0 = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          ptr_d = (gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
          if (div0) begin
            state_d = RESP;
          end else begin
            cnt_d   = CNT_W'(ALU_LATENCY);
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Ready is masked during reset so the grant never leaks out while rst is high.
  always_comb begin
    req_ready = ((state_q == IDLE) && !rst) ? grant : '0;
    rsp_valid = (state_q == RESP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_mode_q <= '0;
      rsp_id_q   <= '0;
      rsp_data_q <= '0;
    end else if (accept) begin
      rsp_id_q <= gnt_idx;
      if (div0) begin
        rsp_data_q <= ERR_DATA;
      end else begin
        alu_a_q    <= sel_a;
        alu_b_q    <= sel_b;
        alu_mode_q <= sel_mode;
      end
    end else if ((state_q == EXEC) && (cnt_q == '0)) begin
      rsp_data_q <= alu_y;
    end
  end

`ifdef ALU_SCHED_DIV0_CHECK_EN
  logic rsp_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         rsp_err_q <= 1'b0;
    else if (accept) rsp_err_q <= div0;
  end

  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_mode = alu_mode_q;
  assign rsp_id   = rsp_id_q;
  assign rsp_data = rsp_data_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_4_bit_sched.sv
`default_nettype none
// =============================================================================
// Module   : tb_alu_4_bit_sched
// Purpose  : Scoreboard bench for alu_4_bit_sched with a behavioural ALU model.
// Revision : 1.0 - initial release
// =============================================================================
module tb_alu_4_bit_sched;
  import alu_sched_pkg::*;

  localparam int N  = 4;
  localparam int L  = 1;
  localparam int IW = $clog2(N);

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid, req_ready;
  logic [4*N-1:0] req_a, req_b;
  logic [3*N-1:0] req_mode;
  logic [3:0]     alu_a, alu_b;
  logic [2:0]     alu_mode;
  logic [7:0]     alu_y;
  logic           rsp_valid;
  logic           rsp_ready = 1'b1;
  logic [IW-1:0]  rsp_id;
  logic [7:0]     rsp_data;
  logic           rsp_err;

  always #5 clk = ~clk;

  alu_4_bit_sched #(.NUM_REQ(N), .ALU_LATENCY(L)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_mode(req_mode),
    .alu_a(alu_a), .alu_b(alu_b), .alu_mode(alu_mode), .alu_y(alu_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  function automatic logic [7:0] alu_f(logic [3:0] a, logic [3:0] b, logic [2:0] m);
    int ia, ib;
    ia = int'(a);
    ib = int'(b);
    case (m)
      3'b000:          return 8'(ia + ib);
      3'b001:          return 8'(ia - ib);
      3'b010, 3'b110:  return 8'(ia * ib);
      3'b011:          return (ib == 0) ? 8'hFF : 8'(ia / ib);
      3'b100:          return {4'h0, a & b};
      3'b101:          return {4'h0, a | b};
      default:         return {4'h0, ~a};
    endcase
  endfunction

  // Behavioural ALU: result appears L edges after operands change.
  logic [7:0] pipe [L];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < L; i++) pipe[i] <= 8'h00;
    end else begin
      pipe[0] <= alu_f(alu_a, alu_b, alu_mode);
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign alu_y = pipe[L-1];

  logic       pend [N];
  logic [3:0] op_a [N];
  logic [3:0] op_b [N];
  logic [2:0] op_m [N];

  always_comb begin
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_mode  = '0;
    for (int i = 0; i < N; i++) begin
      req_valid[i]      = pend[i];
      req_a[4*i +: 4]   = op_a[i];
      req_b[4*i +: 4]   = op_b[i];
      req_mode[3*i +: 3] = op_m[i];
    end
  end

  typedef struct {
    int         id;
    logic [7:0] data;
    logic       err;
    int         due;
  } exp_t;

  exp_t       sb [$];
  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  int         ptr_m = 0;
  bit         busy = 1'b0;
  logic [3:0] last_a = 4'h0, last_b = 4'h0;
  logic [2:0] last_m = 3'h0;

  always_ff @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic post(int i, logic [3:0] a, logic [3:0] b, logic [2:0] m);
    pend[i] = 1'b1;
    op_a[i] = a;
    op_b[i] = b;
    op_m[i] = m;
  endtask

  // One clock: predict the grant, check it, push the expected response.
  task automatic tick();
    int         g;
    int         c;
    bit         dz;
    exp_t       e;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    #1;
    g = -1;
    if (!busy) begin
      for (int k = 0; k < N; k++) begin
        c = (ptr_m + k) % N;
        if (g < 0 && pend[c]) g = c;
      end
    end
    exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("alu_operands", {21'h0, alu_a, alu_b, alu_mode}, {21'h0, last_a, last_b, last_m});
    if (rsp_valid && rsp_ready) busy = 1'b0;
    if (g >= 0) begin
      dz = 1'b0;
`ifdef ALU_SCHED_DIV0_CHECK_EN
      dz = (op_m[g] == 3'b011) && (op_b[g] == 4'd0);
`endif
      e.id = g;
      if (dz) begin
        e.data = 8'hFF;
        e.err  = 1'b1;
        e.due  = cyc + 2;
      end else begin
        e.data = alu_f(op_a[g], op_b[g], op_m[g]);
        e.err  = 1'b0;
        e.due  = cyc + L + 2;
        last_a = op_a[g];
        last_b = op_b[g];
        last_m = op_m[g];
      end
      sb.push_back(e);
      ptr_m = (g + 1) % N;
      busy  = 1'b1;
    end
    @(posedge clk);
    #1;
    if (g >= 0) pend[g] = 1'b0;
  endtask

  task automatic run(int n);
    repeat (n) tick();
  endtask

  task automatic do_reset(int cycles);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_err",   32'(rsp_err),   32'h0);
    chk("rst_rsp_data",  32'(rsp_data),  32'h0);
    chk("rst_rsp_id",    32'(rsp_id),    32'h0);
    chk("rst_alu",       {21'h0, alu_a, alu_b, alu_mode}, 32'h0);
    busy   = 1'b0;
    ptr_m  = 0;
    last_a = 4'h0;
    last_b = 4'h0;
    last_m = 3'h0;
    sb.delete();
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: pops one expectation per new response and checks it is held stable.
  bit   have = 1'b0;
  exp_t cur;
  always @(negedge clk) begin
    #2;
    if (rst) begin
      have = 1'b0;
    end else if (rsp_valid === 1'b1) begin
      if (!have) begin
        if (sb.size() == 0) begin
          chk("unexpected_rsp", 32'h1, 32'h0);
        end else begin
          cur = sb.pop_front();
          chk("rsp_id",      32'(rsp_id),   32'(cur.id));
          chk("rsp_data",    32'(rsp_data), 32'(cur.data));
          chk("rsp_err",     32'(rsp_err),  32'(cur.err));
          chk("rsp_latency", 32'(cyc),      32'(cur.due));
        end
        have = 1'b1;
      end else begin
        chk("rsp_hold", {23'h0, rsp_err, rsp_data}, {23'h0, cur.err, cur.data});
      end
      if (rsp_ready) have = 1'b0;
    end
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0;
      op_a[i] = 4'h0;
      op_b[i] = 4'h0;
      op_m[i] = 3'h0;
    end

    do_reset(2);

    // single request from id 2: 10 + 8
    post(2, 4'b1010, 4'b1000, ALU_ADD);
    run(6);

    // all four continuously valid, multiply 10 * 2
    do_reset(1);
    for (int i = 0; i < N; i++) post(i, 4'b1010, 4'b0010, ALU_MUL);
    repeat (20) begin
      tick();
      for (int i = 0; i < N; i++) if (!pend[i]) post(i, 4'b1010, 4'b0010, ALU_MUL);
    end
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    run(6);

    // backpressure on a divide, with another request waiting
    post(0, 4'b1010, 4'b0010, ALU_DIV);
    rsp_ready = 1'b0;
    tick();
    post(1, 4'b0011, 4'b0101, ALU_OR);
    run(7);
    rsp_ready = 1'b1;
    run(8);

    // reset while a subtract is executing
    post(1, 4'b0101, 4'b1111, ALU_SUB);
    tick();
    post(0, 4'b0111, 4'b0001, ALU_AND);
    post(2, 4'b1100, 4'b0011, ALU_NOT);
    do_reset(2);
    run(12);

    // divide by zero
    post(3, 4'b1010, 4'b0000, ALU_DIV);
    run(6);

    // requester 1 drops its request while 0 is served
    do_reset(1);
    post(0, 4'b0110, 4'b0110, ALU_MUL2);
    post(1, 4'b0001, 4'b0001, ALU_ADD);
    tick();
    pend[1] = 1'b0;
    post(3, 4'b1111, 4'b1111, ALU_ADD);
    run(10);

    // randomized traffic with random backpressure and occasional drops
    repeat (400) begin
      tick();
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 3) == 0)
          post(i, 4'($urandom), 4'($urandom_range(0, 7) == 0 ? 0 : $urandom), 3'($urandom));
        else if (pend[i] && busy && $urandom_range(0, 15) == 0)
          pend[i] = 1'b0;
      end
    end

    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    rsp_ready = 1'b1;
    for (int n = 0; n < 50 && (sb.size() != 0 || busy); n++) tick();
    chk("drain_empty", 32'(sb.size()), 32'h0);
    run(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
